sm3_cmprss: RTL

SM3_CMPRSS -- requirements
Module: sm3_cmprss

---
 rtl/sm3_cmprss.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sm3_cmprss.sv
// SM3 compression core: one round per valid beat, chaining value kept
// across blocks, registered digest pulse on the last round of a message.
module sm3_cmprss (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  expnd_otpt_wj,
  input  logic [31:0]  expnd_otpt_wjj,
  input  logic         expnd_otpt_vld,
  input  logic         expnd_otpt_lst,
  output logic [255:0] cmprss_otpt_res,
  output logic         cmprss_otpt_vld,
  output logic         cmprss_err
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [255:0] IV = {
    32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
    32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e
  };
  localparam logic [31:0] T_LO = 32'h79cc4519;
  localparam logic [31:0] T_HI = 32'h7a879d8a;

  function automatic logic [31:0] rol(
    input logic [31:0] x,
    input logic [4:0]  n
  );
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rol(x, 5'd9) ^ rol(x, 5'd17);
  endfunction

  state_e         state_q, state_d;
  logic [5:0]     j_q, j_d;
  logic [255:0]   v_q, v_d;
  logic [255:0]   w_q, w_d;
  logic [255:0]   res_q, res_d;
  logic           ovld_q, ovld_d;
  logic           err_q, err_d;

  logic [31:0]    wa, wb, wc, wd, we, wf, wg, wh;
  logic [31:0]    tj, a12, ss1, ss2, ff, gg, tt1, tt2;
  logic [255:0]   rnd, v_nxt;
  logic           hi, last, abort;

  // Single round datapath on the current working registers
  always_comb begin
    {wa, wb, wc, wd, we, wf, wg, wh} = w_q;
    hi    = (j_q >= 6'd16);
    tj    = hi ? T_HI : T_LO;
    a12   = rol(wa, 5'd12);
    ss1   = rol(a12 + we + rol(tj, j_q[4:0]), 5'd7);
    ss2   = ss1 ^ a12;
    ff    = hi ? ((wa & wb) | (wa & wc) | (wb & wc))
               : (wa ^ wb ^ wc);
    gg    = hi ? ((we & wf) | (~we & wg))
               : (we ^ wf ^ wg);
    tt1   = ff + wd + ss2 + expnd_otpt_wjj;
    tt2   = gg + wh + ss1 + expnd_otpt_wj;
    rnd   = {tt1, wa, rol(wb, 5'd9), wc,
             p0(tt2), we, rol(wf, 5'd19), wg};
    v_nxt = v_q ^ rnd;
    last  = (j_q == 6'd63);
    abort = expnd_otpt_lst && !last;
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    v_d     = v_q;
    w_d     = w_q;
    res_d   = res_q;
    ovld_d  = 1'b0;
    err_d   = err_q;
    if (expnd_otpt_vld) begin
      state_d = RUN;
      unique case (1'b1)
        abort: begin
          err_d   = 1'b1;
          j_d     = 6'd0;
          v_d     = IV;
          w_d     = IV;
          state_d = IDLE;
        end
        last: begin
          j_d = 6'd0;
          if (expnd_otpt_lst) begin
            res_d   = v_nxt;
            ovld_d  = 1'b1;
            v_d     = IV;
            w_d     = IV;
            state_d = IDLE;
          end else begin
            v_d = v_nxt;
            w_d = v_nxt;
          end
        end
        default: begin
          j_d = j_q + 6'd1;
          w_d = rnd;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      j_q     <= 6'd0;
      v_q     <= IV;
      w_q     <= IV;
      res_q   <= '0;
      ovld_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      v_q     <= v_d;
      w_q     <= w_d;
      res_q   <= res_d;
      ovld_q  <= ovld_d;
      err_q   <= err_d;
    end
  end

  assign cmprss_otpt_res = res_q;
  assign cmprss_otpt_vld = ovld_q;
  assign cmprss_err      = err_q;

endmodule
